fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side adapter placed directly downstream of the dual-clock FIFO, in the read clock domain. Converts the FIFO's pop-request interface (increment strobe, one-cycle-latency registered read data, registered empty flag) into a first-word-fall-through valid/ready stream. A 3-entry local buffer sustains one word per cycle with no combinational path from `I_tready` to the FIFO pop strobe. Also provides a delivered-word counter for debug.

## Interface
- `DSIZE`, 8: data word width; must equal the FIFO's data width.
- `I_clk` in 1: read-domain clock, the same clock that drives the FIFO read side.
- `I_rst_n` in 1: asynchronous, active-low reset.
- `O_rinc` out 1: pop strobe to the FIFO read increment input.
- `I_rdata` in DSIZE: FIFO read data. Valid in the cycle after `O_rinc`=1.
- `I_rempty` in 1: FIFO registered empty flag.
- `O_tdata` out DSIZE: stream data (head of the local buffer).
- `O_tvalid` out 1: stream valid.
- `I_tready` in 1: stream ready from the consumer.
- `O_level` out 2: local buffer occupancy, 0..3.
- `O_cnt` out 32: count of words accepted on the stream, wraps.

## Operation
- **Local buffer:** 3 registers, write pointer and read pointer each 0..2, wrapping 2→0, plus a 2-bit level.
  - `O_tdata` = buffer[rd_ptr].
  - `O_tvalid` = (level != 0).
- **Pending flag:** `S_pend` is a 1-bit register, set to `O_rinc` every cycle. It means "FIFO data arrives on `I_rdata` this cycle".
- **Pop rule (combinational):** `O_rinc` = !`I_rempty` && (level + `S_pend` < 3).
  - Depends only on registered state and `I_rempty`, never on `I_tready`.
  - Never asserted while `I_rempty`=1.
- **Write:** when `S_pend`=1, `I_rdata` is written to buffer[wr_ptr] and wr_ptr advances. The pop rule guarantees space; overflow is impossible by construction.
- **Read:** when `O_tvalid` && `I_tready`, rd_ptr advances and `O_cnt` increments (2^32−1 → 0).
- **Level update:**
  - Write and read in the same cycle: level unchanged.
  - Write only: +1.
  - Read only: −1.
- **Stream rules:** while `O_tvalid`=1 and `I_tready`=0, `O_tdata` and `O_tvalid` hold stable. Words leave in exact FIFO order with no duplication or loss.
- **Reset values:** buffer contents don't-care.
  - `O_tvalid`=0, `O_level`=0, `O_cnt`=0, `O_rinc`=0 (forced low during reset).
  - `S_pend`=0, both pointers = 0.
- **Reset mid-operation:** buffered words and any in-flight word are discarded. The FIFO's read reset must be asserted in the same window (integration requirement), because an in-flight pop lost to reset desynchronizes the two blocks.

## Timing
- **Pop-to-data:** `O_rinc`=1 in cycle t → `I_rdata` valid in t+1 → buffer write at the end of t+1 → visible on `O_tdata` in t+2 if the buffer was empty.
- **First word:** `I_rempty` falls in cycle t with an idle block → `O_rinc`=1 in t → `O_tvalid`=1 in t+2.
- **Throughput:** `I_tready` held at 1 with the FIFO non-empty gives one word per cycle. Steady state is level=1, `S_pend`=1.
- **Backpressure:** `I_tready`=0 → level reaches 3 and `S_pend`=0 → `O_rinc` stays 0 until a word is accepted.
  - After acceptance, `O_rinc` re-asserts in the next cycle (level 2 + pend 0 < 3).
- **Empty mid-burst:** `I_rempty`=1 in cycle t → `O_rinc`=0 in t. Words already buffered or in flight still drain.
- **Counter:** `O_cnt` updates on the clock edge that ends the accepting cycle.

## Test plan
- **Reset:** assert `I_rst_n`=0 asynchronously mid-burst with level=2 → all outputs go to reset values immediately, without a clock edge; after release and FIFO refill, the first word is the FIFO head.
- **Latency:** FIFO preloaded with 0x11, 0x22, 0x33, `I_tready`=1, `I_rempty` falls in cycle 0 → `O_rinc`=1 in cycles 0–2; `O_tdata` shows 0x11/0x22/0x33 in cycles 2/3/4; `O_cnt`=3 after cycle 4.
- **Backpressure:** 8 words queued, `I_tready`=0 → `O_rinc` asserts in exactly 3 cycles, then stops; level=3; `O_tdata` holds word 0 stable. Release ready → all 8 words arrive in order with no gaps after the first.
- **Random ready:** 1000 words with 50% random `I_tready` and random FIFO writes → scoreboard shows in-order, lossless delivery; `O_level` never exceeds 3; `O_rinc` is never 1 while `I_rempty`=1.
- **Wrap:** force `O_cnt` to 0xFFFFFFFE, then accept 3 words → `O_cnt` goes 0xFFFFFFFF, 0x0, 0x1. Buffer pointers wrap 2→0 repeatedly across 10 words with data intact.
- **Simultaneous:** level=1, `S_pend`=1, `I_tready`=1 → level stays 1 and the new head is the arriving word's predecessor order, with FIFO order preserved.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side adapter that turns the dual-clock FIFO's pop
// interface into a first-word-fall-through valid/ready stream.
//
// Ports
//   I_clk, I_rst_n : read-domain clock, async active-low reset
//   O_rinc         : pop strobe to the FIFO read increment
//   I_rdata        : FIFO read data, valid the cycle after O_rinc
//   I_rempty       : FIFO registered empty flag
//   O_tdata        : stream data (buffer head)
//   O_tvalid       : stream valid
//   I_tready       : stream ready from the consumer
//   O_level        : local buffer occupancy, 0..3
//   O_cnt          : words accepted on the stream, wraps
module fifo_rd_stream #(
    parameter int unsigned DSIZE = 8
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    output logic             O_rinc,
    input  logic [DSIZE-1:0] I_rdata,
    input  logic             I_rempty,
    output logic [DSIZE-1:0] O_tdata,
    output logic             O_tvalid,
    input  logic             I_tready,
    output logic [1:0]       O_level,
    output logic [31:0]      O_cnt
);

    localparam int unsigned DEPTH = 3;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned LVL_W = 2;
    localparam int unsigned CNT_W = 32;

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pop only when the word (plus any in-flight word) is guaranteed a slot;
    // held low while reset is asserted so no pop is issued into a reset window.
    assign O_rinc = I_rst_n && !I_rempty
                    && ((3'(level_q) + 3'(pend_q)) < 3'(DEPTH));

    assign wr_en    = pend_q;
    assign O_tvalid = (level_q != '0);
    assign rd_en    = O_tvalid && I_tready;
    assign O_tdata  = mem_q[rd_ptr_q];
    assign O_level  = level_q;
    assign O_cnt    = cnt_q;

    // Next-state for pointers, level and delivered-word counter
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_en) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            cnt_d    = cnt_q + CNT_W'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            pend_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            pend_q   <= O_rinc;
        end
    end

    // Counter only loads on an accepted word
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            cnt_q <= '0;
        end else if (rd_en) begin
            cnt_q <= cnt_d;
        end
    end

    // Data storage needs no reset; contents are qualified by level
    always_ff @(posedge I_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= I_rdata;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed + randomised bench for fifo_rd_stream with a behavioural FIFO
// read-side model (one-cycle read latency, registered empty flag).
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rinc;
    logic [7:0]  rdata = 8'h00;
    logic        rempty = 1'b1;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic [1:0]  level;
    logic [31:0] cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mem[$];
    logic [7:0] exp_q[$];

    fifo_rd_stream #(.DSIZE(8)) dut (
        .I_clk    (clk),
        .I_rst_n  (rst_n),
        .O_rinc   (rinc),
        .I_rdata  (rdata),
        .I_rempty (rempty),
        .O_tdata  (tdata),
        .O_tvalid (tvalid),
        .I_tready (tready),
        .O_level  (level),
        .O_cnt    (cnt)
    );

    always #5 clk = ~clk;

    // FIFO read-side model
    always @(posedge clk) begin
        if (!rst_n) begin
            rempty <= 1'b1;
        end else begin
            if (rinc && mem.size() > 0) begin
                rdata <= mem[0];
                mem.delete(0);
            end
            rempty <= (mem.size() == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic push(input logic [7:0] w);
        mem.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: order, stability under stall, no pop while empty
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (rinc) chk("rinc_while_empty", 32'(rempty), 32'd0);
            if (prev_stall) begin
                chk("hold_valid", 32'(tvalid), 32'd1);
                chk("hold_data", 32'(tdata), 32'(prev_data));
            end
            if (tvalid && tready) begin
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("sb_order", 32'(tdata), 32'(exp_q[0]));
                    exp_q.delete(0);
                end
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
        end
    end

    logic [5:0] lat_rinc  = 6'b000111;
    logic [5:0] lat_valid = 6'b011100;
    logic [7:0] lat_data [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};

    initial begin
        int pushed;
        int guard;
        rst_n  = 1'b0;
        tready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_cnt", cnt, 32'd0);
        chk("rst_rinc", 32'(rinc), 32'd0);
        drive_pt();
        rst_n = 1'b1;

        // Latency: three preloaded words, ready held high
        drive_pt();
        tready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33);
        for (int c = 0; c < 6; c++) begin
            drive_pt();
            @(negedge clk);
            chk($sformatf("lat_rinc_c%0d", c), 32'(rinc), 32'(lat_rinc[c]));
            chk($sformatf("lat_valid_c%0d", c), 32'(tvalid), 32'(lat_valid[c]));
            if (lat_valid[c]) chk($sformatf("lat_data_c%0d", c), 32'(tdata), 32'(lat_data[c]));
        end
        chk("lat_cnt", cnt, 32'd3);
        chk("lat_level", 32'(level), 32'd0);

        // Backpressure: 8 words queued with ready low
        drive_pt();
        tready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(8'h80 + i));
        for (int c = 0; c < 6; c++) begin
            drive_pt();
            @(negedge clk);
            chk($sformatf("bp_rinc_c%0d", c), 32'(rinc), (c < 3) ? 32'd1 : 32'd0);
            if (c >= 2) chk($sformatf("bp_head_c%0d", c), 32'(tdata), 32'h80);
            if (c == 4) chk("bp_level_full", 32'(level), 32'd3);
        end
        drive_pt();
        tready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c < 8) begin
                chk($sformatf("bp_rel_valid_%0d", c), 32'(tvalid), 32'd1);
                chk($sformatf("bp_rel_data_%0d", c), 32'(tdata), 32'(8'h80 + c));
            end else begin
                chk("bp_rel_done", 32'(tvalid), 32'd0);
            end
            if (c == 0) chk("bp_rel_rinc_off", 32'(rinc), 32'd0);
            if (c == 1) chk("bp_rel_rinc_on", 32'(rinc), 32'd1);
            if (c == 2 || c == 3) chk($sformatf("simul_level_%0d", c), 32'(level), 32'd1);
            drive_pt();
        end

        // Wrap: counter preset near the top, 10 words at full rate
        tready = 1'b0;
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        @(negedge clk);
        chk("wrap_preset", cnt, 32'hFFFF_FFFE);
        drive_pt();
        tready = 1'b1;
        for (int i = 0; i < 10; i++) push(8'(8'h50 + i));
        for (int c = 0; c < 13; c++) begin
            drive_pt();
            @(negedge clk);
            chk($sformatf("wrap_cnt_c%0d", c), cnt,
                32'hFFFF_FFFE + 32'((c < 2) ? 0 : ((c - 2 > 10) ? 10 : c - 2)));
            if (c >= 2 && c < 12) chk($sformatf("wrap_data_c%0d", c), 32'(tdata), 32'(8'h50 + c - 2));
            if (c == 12) chk("wrap_idle", 32'(tvalid), 32'd0);
        end

        // Async reset mid-burst at level 2
        drive_pt();
        tready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(8'hC0 + i));
        for (int c = 0; c < 4; c++) begin
            drive_pt();
            @(negedge clk);
        end
        chk("rst_mid_level_pre", 32'(level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tvalid", 32'(tvalid), 32'd0);
        chk("rst_mid_level", 32'(level), 32'd0);
        chk("rst_mid_cnt", cnt, 32'd0);
        chk("rst_mid_rinc", 32'(rinc), 32'd0);
        mem.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_pt();
        tready = 1'b1;
        push(8'hA0); push(8'hA1); push(8'hA2);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!tvalid && guard < 10);
        chk("rst_first_valid", 32'(tvalid), 32'd1);
        chk("rst_first_word", 32'(tdata), 32'hA0);
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            drive_pt();
            guard++;
        end
        chk("rst_drain", 32'(exp_q.size()), 32'd0);

        // Random ready and random FIFO writes
        pushed = 0;
        guard  = 0;
        while (pushed < 1000 && guard < 20000) begin
            drive_pt();
            tready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                push(8'($urandom_range(0, 255)));
                pushed++;
            end
            guard++;
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 10000) begin
            drive_pt();
            tready = 1'($urandom_range(0, 1));
            guard++;
        end
        chk("rand_drain", 32'(exp_q.size()), 32'd0);
        drive_pt();
        tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rand_end_level", 32'(level), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
